branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- EX-stage resolution unit; the consumer end of the branch predictor.
- Evaluates conditional branches (beq/bne/blt/bge/bltu/bgeu) and jalr in EX, then compares each outcome with the prediction carried down the pipe.
- On mismatch, issues a one-cycle pipeline flush and a redirect PC.
- Presents the failed branch's type, pc and actual outcome as held "_branch_failed" signals for predictor rollback, and emits RAS undo strobes.

Parameters:
- XLEN, 32, data/address width
- PERF_CNT_WIDTH, 32, width of the optional saturating performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- PL_stall  in  1  pipeline stall; EX contents not advancing
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- br_type  in  6  branch one-hot {bgeu,bltu,bge,blt,bne,beq}; 0 = not a B-type
- jalr  in  1  EX instruction is jalr
- rs1_data  in  XLEN  operand 1
- rs2_data  in  XLEN  operand 2
- pc  in  XLEN  EX instruction pc
- imme  in  XLEN  sign-extended immediate
- pred_taken  in  1  B-type direction predicted at fetch
- jalr_pc_prediction  in  XLEN  jalr target predicted at fetch (RAS)
- ras_push_id  in  1  ID-stage instruction pushed the RAS this cycle
- ras_pop_id  in  1  ID-stage instruction popped the RAS this cycle
- corrected_result  out  1  actual B-type direction (combinational, EX cycle)
- PL_flush  out  1  flush IF/ID, one-cycle pulse
- redirect_pc  out  XLEN  correct next pc, valid while PL_flush=1
- br_type_branch_failed  out  6  one-hot type of the last mispredicted B-type
- B_type_branch_failed  out  1  OR of br_type_branch_failed
- pc_branch_failed  out  XLEN  pc of the last mispredicted branch
- B_type_result_branch_failed  out  1  actual direction of that branch
- ras_rollback_pop  out  1  undo a wrong-path push
- ras_rollback_push  out  1  undo a wrong-path pop

Behaviour:
- Resolve enable: res_en = ex_valid && !PL_stall && state==IDLE.
- Type decode when more than one br_type bit is set: lowest set bit wins.
- Conditions:
  - beq: rs1==rs2; bne: rs1!=rs2.
  - blt/bge: signed compare; bltu/bgeu: unsigned compare.
  - bge/bgeu are the exact complement of blt/bltu (equality is taken).
- corrected_result = evaluated condition whenever br_type!=0; 0 otherwise.
- Mispredict, evaluated in cycle T:
  - B-type: corrected_result != pred_taken.
  - jalr: ((rs1+imme) & ~1) != jalr_pc_prediction.
  - If br_type!=0 and jalr are both set, B-type takes priority and jalr is ignored.
- Target arithmetic is modulo 2^XLEN (wrap-around with no error):
  - B-type taken: pc+imme; B-type not taken: pc+4.
  - jalr: (rs1+imme) & ~1.
- FSM has two states, IDLE and FLUSH. Reset state is IDLE.
  - IDLE -> FLUSH when res_en && mispredict in T.
  - FLUSH -> IDLE unconditionally after one cycle, including when PL_stall=1. Flush overrides stall.
- In FLUSH (cycle T+1):
  - PL_flush=1 and redirect_pc is registered from T.
  - ras_rollback_pop = registered ras_push_id(T); ras_rollback_push = registered ras_pop_id(T).
  - EX inputs are ignored; that instruction is wrong-path.
- Failed-info registers (br_type_branch_failed, pc_branch_failed, B_type_result_branch_failed):
  - Loaded at T+1 edge only on a B-type mispredict.
  - Held until the next B-type mispredict.
  - A jalr mispredict does not load them; it clears br_type_branch_failed to 0.
- Back-to-back: a mispredicting branch arriving in FLUSH is not resolved. Resolution resumes at T+2.
- Reset (including mid-FLUSH): state IDLE, PL_flush 0, redirect_pc 0, all failed registers 0, rollback strobes 0, counters 0.

Optional Feature:
- Macro BRANCH_RESOLVER_PERF_CNT_EN.
- When defined, adds two outputs, each PERF_CNT_WIDTH wide and saturating at all-ones:
  - branch_cnt: increments on each res_en with br_type!=0 or jalr.
  - mispredict_cnt: increments on each IDLE->FLUSH transition.
- When undefined, neither the ports nor the logic exist.

Test Plan:
- Correct beq: rs1=rs2=5, pred_taken=1, pc=0x100, imme=0x20 -> corrected_result=1; PL_flush stays 0; failed registers unchanged.
- Wrong blt: rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imme=0x40 -> next cycle PL_flush=1 for exactly 1 cycle, redirect_pc=0x240, br_type_branch_failed=6'b000100, pc_branch_failed=0x200, B_type_result_branch_failed=1.
- Unsigned variant of the same operands, bltu, pred_taken=1 -> not taken; PL_flush pulse with redirect_pc=0x204 and B_type_result_branch_failed=0.
- jalr rs1=0x1001, imme=0, jalr_pc_prediction=0x2000, ras_push_id=1 -> PL_flush, redirect_pc=0x1000, ras_rollback_pop=1 for 1 cycle, br_type_branch_failed=0.
- Mispredict with PL_stall=1 in FLUSH, plus a second mispredicting bne present during FLUSH -> single PL_flush pulse; second branch ignored; FSM back in IDLE.
- rst_n=0 asserted during FLUSH -> all outputs 0 next cycle. With BRANCH_RESOLVER_PERF_CNT_EN, counters preloaded near all-ones stay at all-ones after further events.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage branch/jalr resolution against the fetch-time prediction.
// A mispredict raises a one-cycle PL_flush with a registered redirect pc, latches the
// failed B-type info for predictor rollback and emits RAS undo strobes.
// Optional feature: define BRANCH_RESOLVER_PERF_CNT_EN to add the saturating
// branch_cnt / mispredict_cnt outputs.
module branch_resolver #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned PERF_CNT_WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PL_stall,
   input  logic            ex_valid,
   input  logic [5:0]      br_type,
   input  logic            jalr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imme,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] jalr_pc_prediction,
   input  logic            ras_push_id,
   input  logic            ras_pop_id,
   output logic            corrected_result,
   output logic            PL_flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic [5:0]      br_type_branch_failed,
   output logic            B_type_branch_failed,
   output logic [XLEN-1:0] pc_branch_failed,
   output logic            B_type_result_branch_failed,
   output logic            ras_rollback_pop,
   output logic            ras_rollback_push
`ifdef BRANCH_RESOLVER_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] branch_cnt,
   output logic [PERF_CNT_WIDTH-1:0] mispredict_cnt
`endif
);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   redirect_q;
   logic [5:0]        bt_failed_q;
   logic [XLEN-1:0]   pc_failed_q;
   logic              res_failed_q;
   logic              rb_pop_q, rb_push_q;

   logic [5:0]        br_sel;
   logic              is_b, is_j, cond, mispredict, res_en, go_flush;
   logic [XLEN-1:0]   jalr_sum, jalr_tgt, b_tgt, tgt;

   // Isolate the lowest set br_type bit so malformed multi-hot types resolve deterministically.
   assign br_sel = br_type & (~br_type + 6'd1);
   assign is_b   = |br_type;
   // B-type wins when both are flagged.
   assign is_j   = jalr && !is_b;

   // Evaluate the branch condition for the selected type.
   always_comb begin
      cond = 1'b0;
      unique case (br_sel)
         6'b000001: cond = (rs1_data == rs2_data);
         6'b000010: cond = (rs1_data != rs2_data);
         6'b000100: cond = ($signed(rs1_data) < $signed(rs2_data));
         6'b001000: cond = !($signed(rs1_data) < $signed(rs2_data));
         6'b010000: cond = (rs1_data < rs2_data);
         6'b100000: cond = !(rs1_data < rs2_data);
         default:   cond = 1'b0;
      endcase
   end

   assign corrected_result = is_b ? cond : 1'b0;

   assign jalr_sum = rs1_data + imme;
   assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
   assign b_tgt    = cond ? (pc + imme) : (pc + XLEN'(4));
   assign tgt      = is_b ? b_tgt : jalr_tgt;

   // Compare the resolved outcome against what fetch assumed.
   always_comb begin
      mispredict = 1'b0;
      if (is_b) begin
         mispredict = (cond != pred_taken);
      end else if (is_j) begin
         mispredict = (jalr_tgt != jalr_pc_prediction);
      end
   end

   assign res_en   = ex_valid && !PL_stall && (state_q == StIdle);
   assign go_flush = res_en && mispredict;

   // Next-state and flush output; FLUSH always lasts exactly one cycle, stall or not.
   always_comb begin
      state_d  = state_q;
      PL_flush = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go_flush) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            PL_flush = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, redirect target, RAS undo strobes and failed-branch info.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         redirect_q   <= '0;
         bt_failed_q  <= '0;
         pc_failed_q  <= '0;
         res_failed_q <= 1'b0;
         rb_pop_q     <= 1'b0;
         rb_push_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         // Strobes are loaded only on the flush-entering edge, so they self-clear after one cycle.
         rb_pop_q  <= go_flush && ras_push_id;
         rb_push_q <= go_flush && ras_pop_id;
         if (go_flush) begin
            redirect_q <= tgt;
            if (is_b) begin
               bt_failed_q  <= br_sel;
               pc_failed_q  <= pc;
               res_failed_q <= cond;
            end else begin
               bt_failed_q  <= '0;
            end
         end
      end
   end

   assign redirect_pc                 = redirect_q;
   assign br_type_branch_failed       = bt_failed_q;
   assign B_type_branch_failed        = |bt_failed_q;
   assign pc_branch_failed            = pc_failed_q;
   assign B_type_result_branch_failed = res_failed_q;
   assign ras_rollback_pop            = rb_pop_q;
   assign ras_rollback_push           = rb_push_q;

`ifdef BRANCH_RESOLVER_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (res_en && (is_b || jalr) && (branch_cnt_q != '1)) begin
            branch_cnt_q <= branch_cnt_q + 1'b1;
         end
         if (go_flush && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
         end
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;
`else
   logic unused_perf_width;
   assign unused_perf_width = ^PERF_CNT_WIDTH;
`endif

endmodule
